toggle_edge_detect: RTL and testbench
=====================================

// Module: toggle_edge_detect
// PURPOSE
//  Samples a monitored WIDTH-bit signal every cycle and turns its 0->1 and 1->0 bit transitions into one-cycle toggle-cover pulses.
//  Sits directly upstream of the per-bit toggle-cover reporter and drives that reporter's valid vector (width 2*WIDTH).
//  Keeps a covered-point bitmap and a running count of covered points.
//  Raises all_covered once every rise and fall point has been hit.
// PARAMETERS
//  WIDTH   default 8   number of monitored bits; cover points = 2*WIDTH
//  CNT_W   default $clog2(2*WIDTH+1)   width of covered_cnt (derived, do not override)
// PORTS
//  gbl_clk      in   1        clock
//  reset        in   1        synchronous, active-low reset
//  en           in   1        sampling enable
//  clear        in   1        clear covered map and count (one-cycle pulse)
//  sig          in   WIDTH    monitored signal
//  valid        out  2*WIDTH  toggle pulses: [WIDTH-1:0] rise, [2*WIDTH-1:WIDTH] fall
//  covered_cnt  out  CNT_W    number of distinct points covered since reset/clear
//  all_covered  out  1        covered_cnt == 2*WIDTH
// BEHAVIOUR
//  - Interface: reset reset, synchronous, active-low; clock gbl_clk.
//  - Reset (reset==0 at a gbl_clk edge):
//    - state=IDLE; prev=0; covered map=0.
//    - valid=0, covered_cnt=0, all_covered=0.
//  - FSM IDLE:
//    - en=1 captures prev<=sig and moves to RUN.
//    - valid stays 0 on that edge, so there are no spurious toggles from the reset value.
//  - FSM RUN:
//    - en=1: prev<=sig; hit_r=~prev&sig, hit_f=prev&~sig.
//    - en=0: go to IDLE; valid<=0; prev is not compared on re-arm.
//  - Latency: an edge sampled at clock N appears on registered valid after clock N.
//    - valid is high for exactly one cycle per detected event.
//  - Map/count update:
//    - new = {hit_f,hit_r} & ~map; map |= new.
//    - covered_cnt += popcount(new). Cannot exceed 2*WIDTH, so no saturation logic is needed.
//  - all_covered is registered and asserts in the same cycle covered_cnt reaches 2*WIDTH.
//  - clear:
//    - Clears map and count in any state.
//    - If clear coincides with hits: map<=new hits of that cycle and covered_cnt<=popcount(those hits). Clear is applied first, then the hits.
//    - all_covered drops with clear.
//  - Reset mid-RUN overrides everything, including en and clear.
//  - Multiple bits toggling in one cycle: all corresponding valid bits are set together.
// CONFIGURATION
//  TOGGLE_DEDUP_EN defined:
//    - valid = new only; each point is reported once until clear/reset.
//  TOGGLE_DEDUP_EN undefined:
//    - valid = {hit_f,hit_r} on every toggle.
//    - map, covered_cnt and all_covered still track distinct points exactly as above.
// STRUCTURE
//  - Package toggle_cover_pkg:
//    - state enum (IDLE, RUN).
//    - function cnt_width(w) = $clog2(2*w+1).
//  - Sub-module toggle_popcount: combinational popcount of a 2*WIDTH vector to CNT_W bits.
//  - Everything else is flat in this module.
// TESTING (WIDTH=4, TOGGLE_DEDUP_EN defined unless noted)
//  1. Reset low 2 cycles, then en=1, sig=0000 -> first edge: valid=0, covered_cnt=0, state RUN.
//  2. sig 0000->0101 -> valid=8'b0000_0101 for one cycle, covered_cnt=2.
//  3. sig 0101->0000 -> valid=8'b0101_0000, covered_cnt=4. Then sig 0000->0101 -> valid=0, cnt stays 4.
//  4. Toggle remaining bits 1 and 3 up and down -> covered_cnt=8, all_covered=1 in the same cycle.
//  5. clear=1 while sig 0000->1000 -> valid=8'b0000_1000, covered_cnt=1, all_covered=0.
//  6. en=0 for 3 cycles while sig changes -> valid=0. Reset mid-RUN -> all outputs 0.
//     Rerun step 3 without TOGGLE_DEDUP_EN -> repeated rise gives valid=8'b0000_0101.

Source files
------------

// File: rtl/toggle_cover_pkg.sv
// Shared types and helpers for the toggle-cover front end.
// Holds the sampler state encoding and the covered-count width rule.
`timescale 1ns/1ps

package toggle_cover_pkg;

  // Sampler state: IDLE waits for en to take a baseline sample; RUN compares each new sample
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Width needed to count from 0 up to every rise and fall point of a w-bit signal
  function automatic int cnt_width(input int w);
    return $clog2(2 * w + 1);
  endfunction

endpackage

// File: rtl/toggle_popcount.sv
// Combinational population count of the per-cycle toggle vector.
// The output width is chosen by the parent so the sum can never overflow.
`timescale 1ns/1ps

module toggle_popcount #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 5
) (
  input  logic [IN_W-1:0]  bits_i,
  output logic [OUT_W-1:0] count_o
);

  // Sum the set bits of the input vector
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a value first, so no path leaves it unassigned and no latch is inferred.
    count_o = '0;
    for (int i = 0; i < IN_W; i++) begin
      count_o = count_o + OUT_W'(bits_i[i]);
    end
  end

endmodule

// File: rtl/toggle_edge_detect.sv
// Toggle-cover front end: samples sig each enabled cycle and turns 0->1 and
// 1->0 bit transitions into one-cycle pulses on valid (rise in the low half,
// fall in the high half). Tracks which of the 2*WIDTH points have been seen,
// how many, and whether all of them have been seen.
// Build option: define TOGGLE_DEDUP_EN to report each point only the first
// time it is hit after reset/clear; otherwise every toggle is reported.
`timescale 1ns/1ps

module toggle_edge_detect
  import toggle_cover_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = cnt_width(WIDTH)
) (
  input  logic               gbl_clk,
  input  logic               reset,
  input  logic               en,
  input  logic               clear,
  input  logic [WIDTH-1:0]   sig,
  output logic [2*WIDTH-1:0] valid,
  output logic [CNT_W-1:0]   covered_cnt,
  output logic               all_covered
);

  localparam int              PTS  = 2 * WIDTH;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(PTS);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic [PTS-1:0]     map_q, map_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTS-1:0]     valid_q, valid_d;
  logic               all_q, all_d;

  logic [PTS-1:0]     hits;
  logic [PTS-1:0]     map_base;
  logic [PTS-1:0]     new_pts;
  logic [CNT_W-1:0]   new_cnt;

  // Count how many points are being covered for the first time this cycle
  toggle_popcount #(
    .IN_W  (PTS),
    .OUT_W (CNT_W)
  ) u_popcount (
    .bits_i  (new_pts),
    .count_o (new_cnt)
  );

  // Sampler FSM: the first enabled sample after IDLE only sets the baseline
  always_comb begin
    state_d = state_q;
    prev_d  = en ? sig : prev_q;
    unique case (state_q)
      IDLE:    state_d = en ? RUN : IDLE;
      RUN:     state_d = en ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Edge detection and coverage bookkeeping; clear wipes the map before this cycle's hits land
  always_comb begin
    hits = '0;
    if (state_q == RUN && en) begin
      hits = {prev_q & ~sig, ~prev_q & sig};
    end
    map_base = clear ? '0 : map_q;
    new_pts  = hits & ~map_base;
    map_d    = map_base | new_pts;
    cnt_d    = (clear ? '0 : cnt_q) + new_cnt;
    all_d    = (cnt_d == FULL);
`ifdef TOGGLE_DEDUP_EN
    valid_d  = new_pts;
`else
    valid_d  = hits;
`endif
  end

  // State registers with synchronous active-low reset taking priority over en and clear
  always_ff @(posedge gbl_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (!reset) begin
      state_q <= IDLE;
      prev_q  <= '0;
      map_q   <= '0;
      cnt_q   <= '0;
      valid_q <= '0;
      all_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      map_q   <= map_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      all_q   <= all_d;
    end
  end

  assign valid       = valid_q;
  assign covered_cnt = cnt_q;
  assign all_covered = all_q;

endmodule

// File: tb/tb_toggle_edge_detect.sv
// Self-checking bench for toggle_edge_detect at WIDTH=4.
// Directed scenarios followed by randomized en/clear/reset/sig traffic,
// all compared against a point-set reference model kept in this file.
`timescale 1ns/1ps

module tb_toggle_edge_detect;

  localparam int W     = 4;
  localparam int PTS   = 2 * W;
  localparam int CNT_W = $clog2(2 * W + 1);

  logic             gbl_clk = 1'b0;
  logic             reset   = 1'b0;
  logic             en      = 1'b0;
  logic             clear   = 1'b0;
  logic [W-1:0]     sig     = '0;
  logic [PTS-1:0]   valid;
  logic [CNT_W-1:0] covered_cnt;
  logic             all_covered;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  // Reference model: whether a baseline sample exists, the last sample, and the set of seen points
  bit           m_armed = 1'b0;
  bit [W-1:0]   m_prev  = '0;
  bit           m_seen[PTS];
  logic [PTS-1:0] exp_valid;
  int           exp_cnt;
  bit           dedup;

  toggle_edge_detect #(.WIDTH(W)) dut (
    .gbl_clk     (gbl_clk),
    .reset       (reset),
    .en          (en),
    .clear       (clear),
    .sig         (sig),
    .valid       (valid),
    .covered_cnt (covered_cnt),
    .all_covered (all_covered)
  );

  always #5 gbl_clk = ~gbl_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cycle, obs, exp);
    end
  endtask

  // Advance the model by one clock using the rules as stated, not the RTL structure
  task automatic model_step(input bit r, input bit e, input bit c, input bit [W-1:0] s);
    bit rise, fall;
    exp_valid = '0;
    if (!r) begin
      m_armed = 1'b0;
      m_prev  = '0;
      foreach (m_seen[j]) m_seen[j] = 1'b0;
    end else begin
      if (c) foreach (m_seen[j]) m_seen[j] = 1'b0;
      if (m_armed && e) begin
        for (int i = 0; i < W; i++) begin
          rise = (m_prev[i] == 1'b0) && (s[i] == 1'b1);
          fall = (m_prev[i] == 1'b1) && (s[i] == 1'b0);
          if (rise) begin
            if (!dedup || !m_seen[i]) exp_valid[i] = 1'b1;
            m_seen[i] = 1'b1;
          end
          if (fall) begin
            if (!dedup || !m_seen[W+i]) exp_valid[W+i] = 1'b1;
            m_seen[W+i] = 1'b1;
          end
        end
      end
      if (e) m_prev = s;
      m_armed = e;
    end
    exp_cnt = 0;
    foreach (m_seen[j]) exp_cnt += int'(m_seen[j]);
  endtask

  // Drive one cycle of inputs, clock it, and compare all outputs with the model
  task automatic step(input bit r, input bit e, input bit c, input bit [W-1:0] s);
    reset = r;
    en    = e;
    clear = c;
    sig   = s;
    model_step(r, e, c, s);
    @(posedge gbl_clk);
    #1;
    cycle++;
    check("valid", 32'(valid), 32'(exp_valid));
    check("covered_cnt", 32'(covered_cnt), 32'(exp_cnt));
    check("all_covered", 32'(all_covered), 32'(exp_cnt == PTS));
  endtask

  initial begin
`ifdef TOGGLE_DEDUP_EN
    dedup = 1'b1;
`else
    dedup = 1'b0;
`endif
    foreach (m_seen[j]) m_seen[j] = 1'b0;

    // Reset for two cycles, then take the baseline sample
    step(1'b0, 1'b0, 1'b0, 4'b0000);
    step(1'b0, 1'b1, 1'b1, 4'b1111);
    check("reset_cnt", 32'(covered_cnt), 32'd0);
    step(1'b1, 1'b1, 1'b0, 4'b0000);
    check("arm_valid", 32'(valid), 32'd0);

    // Rises on bits 0 and 2
    step(1'b1, 1'b1, 1'b0, 4'b0101);
    check("rise02_valid", 32'(valid), 32'h05);
    check("rise02_cnt", 32'(covered_cnt), 32'd2);
    step(1'b1, 1'b1, 1'b0, 4'b0101);
    check("pulse_one_cycle", 32'(valid), 32'd0);

    // Falls on bits 0 and 2, then a repeated rise
    step(1'b1, 1'b1, 1'b0, 4'b0000);
    check("fall02_valid", 32'(valid), 32'h50);
    check("fall02_cnt", 32'(covered_cnt), 32'd4);
    step(1'b1, 1'b1, 1'b0, 4'b0101);
    check("repeat_rise_valid", 32'(valid), dedup ? 32'd0 : 32'h05);
    check("repeat_rise_cnt", 32'(covered_cnt), 32'd4);

    // Remaining bits 1 and 3 up and down
    step(1'b1, 1'b1, 1'b0, 4'b1111);
    step(1'b1, 1'b1, 1'b0, 4'b0000);
    check("full_cnt", 32'(covered_cnt), 32'd8);
    check("full_flag", 32'(all_covered), 32'd1);

    // Clear coinciding with a rise on bit 3
    step(1'b1, 1'b1, 1'b1, 4'b1000);
    check("clear_hit_valid", 32'(valid), 32'h08);
    check("clear_hit_cnt", 32'(covered_cnt), 32'd1);
    check("clear_hit_flag", 32'(all_covered), 32'd0);

    // Disabled sampling ignores changes; re-arm does not compare against the old sample
    step(1'b1, 1'b0, 1'b0, 4'b0111);
    step(1'b1, 1'b0, 1'b0, 4'b0001);
    step(1'b1, 1'b0, 1'b0, 4'b1110);
    check("disabled_valid", 32'(valid), 32'd0);
    step(1'b1, 1'b1, 1'b0, 4'b0011);
    check("rearm_valid", 32'(valid), 32'd0);
    step(1'b1, 1'b1, 1'b0, 4'b1100);

    // Reset mid-run overrides en and clear
    step(1'b0, 1'b1, 1'b1, 4'b0011);
    check("midrun_reset_cnt", 32'(covered_cnt), 32'd0);
    check("midrun_reset_valid", 32'(valid), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 49) != 0,
           $urandom_range(0, 9)  != 0,
           $urandom_range(0, 24) == 0,
           W'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
